weight_load_controller: RTL
===========================

Name: weight_load_controller

Overview:
Sequences weight loading into the MATRIX_WIDTH x MATRIX_WIDTH systolic MAC array. On a start command it reads one weight row per cycle from the weight buffer and extends each byte to extended_byte_type. It steers each row into the array's preweight registers with a one-hot row preload strobe. Once every row is staged and the array reports idle, it pulses the array-wide load_weight for the double-buffer swap.

Parameters:
MATRIX_WIDTH, 14, array rows/columns; number of weight rows per tile
WEIGHT_ADDR_WIDTH, 16, weight buffer address width
READ_LATENCY, 1, cycles from weight_rd_en to valid weight_rd_data (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
base_addr  in  WEIGHT_ADDR_WIDTH  address of row 0
row_count  in  $clog2(MATRIX_WIDTH+1)  valid rows; 0 or >MATRIX_WIDTH means MATRIX_WIDTH
signed_weights  in  1  1 = sign-extend, 0 = zero-extend
compute_idle  in  1  array not mid-computation; swap permitted
weight_rd_en  out  1  buffer read strobe
weight_rd_addr  out  WEIGHT_ADDR_WIDTH  buffer read address
weight_rd_data  in  MATRIX_WIDTH*BYTE_WIDTH  row data, column 0 in LSBs
preload_row  out  MATRIX_WIDTH  one-hot preload_weight per array row
preload_data  out  MATRIX_WIDTH*EXTENDED_BYTE_WIDTH  extended row, column 0 in LSBs
load_weight  out  1  array-wide preweight-to-weight transfer
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0; slot counter 0; delay line cleared; in-flight reads discarded. Reset mid-operation aborts the load, and load_weight is not issued.
- States: IDLE -> FETCH -> DRAIN -> WAIT_SWAP -> SWAP -> DONE -> IDLE.
- IDLE: start=1 latches base_addr, effective row_count R and signed_weights, then goes to FETCH.
- FETCH: exactly MATRIX_WIDTH cycles, slot i = 0..MATRIX_WIDTH-1, one slot per cycle. For i<R, weight_rd_en=1 and weight_rd_addr=base_addr+i, with wrap modulo 2^WEIGHT_ADDR_WIDTH. For i>=R, weight_rd_en=0 and a zero-row token enters the delay line. After the last slot, go to DRAIN.
- Delay line: a READ_LATENCY-deep shift of {valid, zero, slot}. When the token exits, preload_row has bit slot set, combinationally in that cycle. preload_data is the extended weight_rd_data, or all-zero for zero tokens.
- Extension: each byte is sign-extended if the latched signed_weights=1, otherwise zero-extended. Example: 8'hFF -> 9'h1FF signed, 9'h0FF unsigned.
- DRAIN: wait until the last token exits, then go to WAIT_SWAP.
- WAIT_SWAP: hold until compute_idle=1, then go to SWAP.
- SWAP: load_weight=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Timing with start in cycle 0: preload of row i in cycle 1+i+READ_LATENCY; last preload in cycle MATRIX_WIDTH+READ_LATENCY. With compute_idle=1, load_weight fires in cycle MATRIX_WIDTH+READ_LATENCY+2 and done in the cycle after.
- busy=1 from cycle 1 through the done cycle inclusive.
- start while busy is ignored. start in the DONE cycle is ignored; a new start is accepted the cycle after done.
- preload_row and load_weight are never asserted in the same cycle.

Optional Feature:
- Macro WEIGHT_LOAD_STALL_COUNT_EN.
- Defined: adds output stall_cycles [15:0]. The count clears on an accepted start and increments each cycle spent in WAIT_SWAP with compute_idle=0. It saturates at 16'hFFFF, holds its value after done, and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- tpu_pkg additions: weight_addr_type (logic [WEIGHT_ADDR_WIDTH-1:0]), enum wlc_state_type {IDLE, FETCH, DRAIN, WAIT_SWAP, SWAP, DONE}, and the zero-extended row constant.
- Reuse existing BYTE_WIDTH, EXTENDED_BYTE_WIDTH and extended_byte_type.
- Sub-module: wlc_token_delay, a parameterised READ_LATENCY-stage shift register for the {valid, zero, slot} token.

Test Plan:
- MATRIX_WIDTH=4, READ_LATENCY=2, base=0x0010, R=4, compute_idle=1, start in cycle 0: reads at addresses 0x10..0x13 in cycles 1-4; preload_row 0001, 0010, 0100, 1000 in cycles 3-6; load_weight in cycle 8; done in cycle 9.
- R=2, signed_weights=1, rd_data byte 0x80: rows 0-1 carry 9'h180 in that column; rows 2-3 preloaded with zero and no reads issued for them.
- compute_idle held 0 for 5 cycles after DRAIN: load_weight delayed exactly 5 cycles; with WEIGHT_LOAD_STALL_COUNT_EN, stall_cycles=5.
- start re-asserted every cycle during an operation: only one load sequence occurs; second start accepted only in the cycle after done.
- rst asserted in cycle 4 mid-FETCH: all outputs 0 next cycle; no preload or load_weight from the aborted load; fresh start works normally.
- base=0xFFFE, R=4: read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared types and constants for the systolic MAC array datapath.
//   BYTE_WIDTH / EXTENDED_BYTE_WIDTH : raw and extended operand widths
//   extended_byte_type               : one extended weight/activation byte
//   weight_addr_type                 : weight buffer address
//   wlc_state_type                   : weight_load_controller FSM states
//   ZERO_EXTENDED_ROW                : an all-zero extended array row
//   extend_byte()                    : sign- or zero-extend one byte
// ----------------------------------------------------------------------------
package tpu_pkg;
  localparam int BYTE_WIDTH             = 8;
  localparam int EXTENDED_BYTE_WIDTH    = 9;
  localparam int TPU_MATRIX_WIDTH       = 14;
  localparam int TPU_WEIGHT_ADDR_WIDTH  = 16;

  typedef logic [BYTE_WIDTH-1:0]            byte_type;
  typedef logic [EXTENDED_BYTE_WIDTH-1:0]   extended_byte_type;
  typedef logic [TPU_WEIGHT_ADDR_WIDTH-1:0] weight_addr_type;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, WAIT_SWAP, SWAP, DONE
  } wlc_state_type;

  localparam logic [TPU_MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] ZERO_EXTENDED_ROW = '0;

  function automatic extended_byte_type extend_byte(input byte_type b, input logic sgn);
    return {{(EXTENDED_BYTE_WIDTH-BYTE_WIDTH){sgn & b[BYTE_WIDTH-1]}}, b};
  endfunction
endpackage

// File: rtl/wlc_token_delay.sv
// ----------------------------------------------------------------------------
// wlc_token_delay
// DEPTH-stage shift register carrying a {valid, zero, slot} token alongside
// the weight buffer read, so the token surfaces in the cycle the read data
// becomes valid.
//   clk, rst         : clock, synchronous active-high reset (clears the line)
//   i_valid/i_zero/i_slot : token entering this cycle
//   o_valid/o_zero/o_slot : token leaving after DEPTH cycles
// ----------------------------------------------------------------------------
module wlc_token_delay #(
  parameter int DEPTH  = 1,
  parameter int SLOT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_zero,
  input  logic [SLOT_W-1:0] i_slot,
  output logic              o_valid,
  output logic              o_zero,
  output logic [SLOT_W-1:0] o_slot
);
  localparam int TW = SLOT_W + 2;

  logic [DEPTH-1:0][TW-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= {i_valid, i_zero, i_slot};
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign {o_valid, o_zero, o_slot} = r_pipe[DEPTH-1];
endmodule

// File: rtl/weight_load_controller.sv
// ----------------------------------------------------------------------------
// weight_load_controller
// Streams one weight tile (MATRIX_WIDTH rows) from the weight buffer into the
// systolic array's preweight registers, then issues the array-wide
// load_weight swap once the array is idle.
//   clk, rst          : clock, synchronous active-high reset (aborts a load)
//   start             : command strobe, honoured only when idle
//   base_addr         : buffer address of row 0
//   row_count         : rows to read; 0 or > MATRIX_WIDTH means a full tile
//   signed_weights    : 1 sign-extends, 0 zero-extends each byte
//   compute_idle      : array may swap weights
//   weight_rd_en/addr : buffer read request
//   weight_rd_data    : buffer row, READ_LATENCY cycles after the request
//   preload_row       : one-hot preload strobe per array row
//   preload_data      : extended row for the strobed array row
//   load_weight       : one-cycle preweight->weight transfer
//   busy, done        : operation in progress / completion pulse
// Optional: define WEIGHT_LOAD_STALL_COUNT_EN to add stall_cycles[15:0],
// the number of cycles spent waiting on compute_idle in the last load.
// ----------------------------------------------------------------------------
module weight_load_controller
  import tpu_pkg::*;
#(
  parameter  int MATRIX_WIDTH      = TPU_MATRIX_WIDTH,
  parameter  int WEIGHT_ADDR_WIDTH = TPU_WEIGHT_ADDR_WIDTH,
  parameter  int READ_LATENCY      = 1,
  localparam int RC_W              = $clog2(MATRIX_WIDTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [WEIGHT_ADDR_WIDTH-1:0]                  base_addr,
  input  logic [RC_W-1:0]                               row_count,
  input  logic                                          signed_weights,
  input  logic                                          compute_idle,
  output logic                                          weight_rd_en,
  output logic [WEIGHT_ADDR_WIDTH-1:0]                  weight_rd_addr,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]            weight_rd_data,
  output logic [MATRIX_WIDTH-1:0]                       preload_row,
  output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0]   preload_data,
  output logic                                          load_weight,
  output logic                                          busy,
  output logic                                          done
`ifdef WEIGHT_LOAD_STALL_COUNT_EN
  ,
  output logic [15:0]                                   stall_cycles
`endif
);
  localparam logic [RC_W-1:0] LAST_SLOT = RC_W'(MATRIX_WIDTH - 1);
  localparam logic [RC_W-1:0] FULL_ROWS = RC_W'(MATRIX_WIDTH);

  wlc_state_type                r_state, w_next;
  logic [WEIGHT_ADDR_WIDTH-1:0] r_base;
  logic [RC_W-1:0]              r_rows, r_slot, w_rows;
  logic                         r_signed;
  logic                         w_accept, w_zero, w_last_out;
  logic                         w_tok_v, w_tok_z;
  logic [RC_W-1:0]              w_tok_slot;

  assign w_rows     = (row_count == '0 || row_count > FULL_ROWS) ? FULL_ROWS : row_count;
  assign w_accept   = (r_state == IDLE) && start;
  // Slots past the requested row count still walk the pipe as zero tokens,
  // so every array row gets a defined preweight.
  assign w_zero     = (r_slot >= r_rows);
  assign w_last_out = w_tok_v && (w_tok_slot == LAST_SLOT);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_rows   <= '0;
      r_signed <= 1'b0;
      r_slot   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base   <= base_addr;
        r_rows   <= w_rows;
        r_signed <= signed_weights;
        r_slot   <= '0;
      end else if (r_state == FETCH) begin
        r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + RC_W'(1);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    weight_rd_en   = 1'b0;
    weight_rd_addr = '0;
    load_weight    = 1'b0;
    done           = 1'b0;
    case (r_state)
      IDLE:      if (start) w_next = FETCH;
      FETCH: begin
        if (!w_zero) begin
          weight_rd_en   = 1'b1;
          weight_rd_addr = r_base + WEIGHT_ADDR_WIDTH'(r_slot);
        end
        if (r_slot == LAST_SLOT) w_next = DRAIN;
      end
      DRAIN:     if (w_last_out) w_next = WAIT_SWAP;
      WAIT_SWAP: if (compute_idle) w_next = SWAP;
      SWAP: begin
        load_weight = 1'b1;
        w_next      = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  wlc_token_delay #(
    .DEPTH  (READ_LATENCY),
    .SLOT_W (RC_W)
  ) u_tok (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_state == FETCH),
    .i_zero  (w_zero),
    .i_slot  (r_slot),
    .o_valid (w_tok_v),
    .o_zero  (w_tok_z),
    .o_slot  (w_tok_slot)
  );

  for (genvar r = 0; r < MATRIX_WIDTH; r++) begin : g_row
    assign preload_row[r] = w_tok_v && (w_tok_slot == RC_W'(r));
  end

  for (genvar c = 0; c < MATRIX_WIDTH; c++) begin : g_col
    assign preload_data[c*EXTENDED_BYTE_WIDTH +: EXTENDED_BYTE_WIDTH] =
      (w_tok_v && !w_tok_z) ? extend_byte(weight_rd_data[c*BYTE_WIDTH +: BYTE_WIDTH], r_signed)
                            : '0;
  end

`ifdef WEIGHT_LOAD_STALL_COUNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall <= '0;
    else if (w_accept)
      r_stall <= '0;
    else if (r_state == WAIT_SWAP && !compute_idle && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end

  assign stall_cycles = r_stall;
`endif
endmodule
